// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch-side initiator for a combinational instruction ROM. Owns the PC,
//   drives it as the ROM byte address, registers the returned word into the
//   fetch/decode boundary and applies taken branches after the MIPS delay
//   slot. A redirect that arrives while the pipe is stalled is parked in a
//   pending slot and applied on the first unstalled edge. Fetching from
//   HALT_ADDR stops the core; loading a misaligned PC raises a sticky error.
//
// Ports
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high
//   instr_address   out  32  ROM byte address (the PC flop)
//   instr_readdata  in   32  ROM word at instr_address, same cycle
//   stall           in   1   hold PC and decode-stage outputs
//   branch_valid    in   1   taken branch/jump for the word in instr_out
//   branch_target   in   32  redirect address
//   instr_out       out  32  instruction for decode
//   pc_out          out  32  address of instr_out
//   pc_plus8        out  32  pc_out + 8 (link address)
//   instr_valid     out  1   instr_out holds a real instruction
//   active          out  1   core running
//   fetch_error     out  1   misaligned redirect seen, sticky until reset
//
// State | Meaning
//   RUN    | fetching and issuing
//   HALTED | PC reached HALT_ADDR, everything frozen
//   ERROR  | misaligned PC load attempted, everything frozen
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus8,
    output logic        instr_valid,
    output logic        active,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t      state_q,          state_d;
    logic [31:0] pc_q,             pc_d;
    logic [31:0] instr_out_q,      instr_out_d;
    logic [31:0] pc_out_q,         pc_out_d;
    logic [31:0] pc_plus8_q,       pc_plus8_d;
    logic        instr_valid_q,    instr_valid_d;
    logic        active_q,         active_d;
    logic        fetch_error_q,    fetch_error_d;
    logic        pending_valid_q,  pending_valid_d;
    logic [31:0] pending_target_q, pending_target_d;

    logic [31:0] next_pc;

    // Live branch beats a parked one: decode only presents both when it is
    // re-issuing the same branch, so the live copy is authoritative.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (branch_valid) begin
            next_pc = branch_target;
        end else if (pending_valid_q) begin
            next_pc = pending_target_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        instr_out_d      = instr_out_q;
        pc_out_d         = pc_out_q;
        pc_plus8_d       = pc_plus8_q;
        instr_valid_d    = instr_valid_q;
        active_d         = active_q;
        fetch_error_d    = fetch_error_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;

        case (state_q)
            RUN: begin
                if (stall) begin
                    if (branch_valid) begin
                        pending_valid_d  = 1'b1;
                        pending_target_d = branch_target;
                    end
                end else if (pc_q == HALT_ADDR) begin
                    // Word at the halt address is never captured.
                    state_d       = HALTED;
                    instr_valid_d = 1'b0;
                    active_d      = 1'b0;
                end else begin
                    // Word at PC is the delay slot when branch_valid is set;
                    // it is always issued.
                    instr_out_d     = instr_readdata;
                    pc_out_d        = pc_q;
                    pc_plus8_d      = pc_q + 32'd8;
                    pending_valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        // Delay slot still lands in instr_out but is not
                        // issued; PC keeps its last good value.
                        state_d       = ERROR;
                        instr_valid_d = 1'b0;
                        active_d      = 1'b0;
                        fetch_error_d = 1'b1;
                    end else begin
                        pc_d          = next_pc;
                        instr_valid_d = 1'b1;
                    end
                end
            end
            HALTED, ERROR: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= RUN;
            pc_q             <= RESET_VECTOR;
            instr_out_q      <= 32'd0;
            pc_out_q         <= 32'd0;
            pc_plus8_q       <= 32'd8;
            instr_valid_q    <= 1'b0;
            active_q         <= 1'b1;
            fetch_error_q    <= 1'b0;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            instr_out_q      <= instr_out_d;
            pc_out_q         <= pc_out_d;
            pc_plus8_q       <= pc_plus8_d;
            instr_valid_q    <= instr_valid_d;
            active_q         <= active_d;
            fetch_error_q    <= fetch_error_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
        end
    end

    assign instr_address = pc_q;
    assign instr_out     = instr_out_q;
    assign pc_out        = pc_out_q;
    assign pc_plus8      = pc_plus8_q;
    assign instr_valid   = instr_valid_q;
    assign active        = active_q;
    assign fetch_error   = fetch_error_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus8;
    logic        instr_valid;
    logic        active;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .stall          (stall),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc_plus8       (pc_plus8),
        .instr_valid    (instr_valid),
        .active         (active),
        .fetch_error    (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2402_0005;
        if (a == 32'hBFC0_0004) return 32'h2403_0007;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign instr_readdata = rom(instr_address);

    typedef struct {
        logic        rst_pulse;
        logic        stall;
        logic        bv;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] pc_out;
        logic        valid;
        logic        act;
        logic        ferr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] po,
                           input logic [31:0] ins, input logic [31:0] p8,
                           input logic v, input logic ac, input logic fe);
        chk({tag, ".instr_address"}, instr_address, a);
        chk({tag, ".pc_out"},        pc_out,        po);
        chk({tag, ".instr_out"},     instr_out,     ins);
        chk({tag, ".pc_plus8"},      pc_plus8,      p8);
        chk({tag, ".instr_valid"},   {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".active"},        {31'd0, active},      {31'd0, ac});
        chk({tag, ".fetch_error"},   {31'd0, fetch_error}, {31'd0, fe});
    endtask

    // Drive inputs in the low phase, clock once, sample 1 ns after the edge,
    // then return in the next low phase.
    task automatic step(input logic s, input logic bv, input logic [31:0] t);
        stall         = s;
        branch_valid  = bv;
        branch_target = t;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic rp, input logic s, input logic bv,
                                input logic [31:0] t, input logic [31:0] a,
                                input logic [31:0] po, input logic v,
                                input logic ac, input logic fe);
        vec_t x;
        x.rst_pulse = rp; x.stall = s; x.bv = bv; x.tgt = t;
        x.addr = a; x.pc_out = po; x.valid = v; x.act = ac; x.ferr = fe;
        vecs.push_back(x);
    endfunction

    initial begin
        // sequential fetch
        add(0, 0, 0, 0,            32'hBFC0_0004, 32'hBFC0_0000, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_0008, 32'hBFC0_0004, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_000C, 32'hBFC0_0008, 1, 1, 0);
        // branch while instr_out is from BFC00008: delay slot then target
        add(0, 0, 1, 32'hBFC0_0100, 32'hBFC0_0100, 32'hBFC0_000C, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_0104, 32'hBFC0_0100, 1, 1, 0);
        // branch pulsed in first of three stall cycles
        add(0, 1, 1, 32'hBFC0_0040, 32'hBFC0_0104, 32'hBFC0_0100, 1, 1, 0);
        add(0, 1, 0, 0,            32'hBFC0_0104, 32'hBFC0_0100, 1, 1, 0);
        add(0, 1, 0, 0,            32'hBFC0_0104, 32'hBFC0_0100, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_0040, 32'hBFC0_0104, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_0044, 32'hBFC0_0040, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_0048, 32'hBFC0_0044, 1, 1, 0);
        // misaligned target: error, PC kept, delay slot captured but invalid
        add(0, 0, 1, 32'hBFC0_0102, 32'hBFC0_0048, 32'hBFC0_0048, 0, 0, 1);
        add(0, 0, 1, 32'hBFC0_0200, 32'hBFC0_0048, 32'hBFC0_0048, 0, 0, 1);
        add(0, 0, 0, 0,            32'hBFC0_0048, 32'hBFC0_0048, 0, 0, 1);
        // live branch beats a parked one and clears it
        add(1, 0, 0, 0,            32'hBFC0_0004, 32'hBFC0_0000, 1, 1, 0);
        add(0, 1, 1, 32'hBFC0_0040, 32'hBFC0_0004, 32'hBFC0_0000, 1, 1, 0);
        add(0, 0, 1, 32'hBFC0_0080, 32'hBFC0_0080, 32'hBFC0_0004, 1, 1, 0);
        add(0, 0, 0, 0,            32'hBFC0_0084, 32'hBFC0_0080, 1, 1, 0);
        // PC wraps FFFFFFFC+4 -> 0 -> halt
        add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hBFC0_0084, 1, 1, 0);
        add(0, 0, 0, 0,            32'h0000_0000, 32'hFFFF_FFFC, 1, 1, 0);
        add(0, 0, 0, 0,            32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 0);
        add(0, 0, 1, 32'hBFC0_0000, 32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 0);
        // JR to 0: delay slot issues, then halt
        add(1, 0, 0, 0,            32'hBFC0_0004, 32'hBFC0_0000, 1, 1, 0);
        add(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 32'hBFC0_0004, 1, 1, 0);
        add(0, 0, 0, 0,            32'h0000_0000, 32'hBFC0_0004, 0, 0, 0);

        reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("reset", 32'hBFC0_0000, 32'd0, 32'd0, 32'd8, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_pulse) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            step(vecs[i].stall, vecs[i].bv, vecs[i].tgt);
            chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].pc_out,
                    rom(vecs[i].pc_out), vecs[i].pc_out + 32'd8,
                    vecs[i].valid, vecs[i].act, vecs[i].ferr);
            @(negedge clk);
        end

        // halted state holds for many cycles regardless of inputs
        for (int i = 0; i < 12; i++) begin
            step(i[1], i[0], 32'hBFC0_0000);
            chk("halt_hold.active", {31'd0, active}, 32'd0);
            chk("halt_hold.instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_hold.instr_address", instr_address, 32'h0000_0000);
            @(negedge clk);
        end

        // asynchronous reset while a redirect is pending
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step(0, 0, 0);
        step(1, 1, 32'hBFC0_0040);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 32'hBFC0_0000, 32'd0, 32'd0, 32'd8, 0, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0);
        chk_all("rst_restart0", 32'hBFC0_0004, 32'hBFC0_0000, 32'h2402_0005,
                32'hBFC0_0008, 1, 1, 0);
        @(negedge clk);
        step(0, 0, 0);
        chk_all("rst_restart1", 32'hBFC0_0008, 32'hBFC0_0004, 32'h2403_0007,
                32'hBFC0_000C, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side initiator for the combinational instruction ROM. It owns the program counter and drives the byte address onto the ROM port, starting at reset vector 0xBFC00000. It registers the returned little-endian word into the fetch/decode boundary and applies taken branches/jumps after the MIPS delay slot. It also detects the halt condition (PC reaching 0x00000000) and misaligned redirect targets.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, fetch address that ends execution.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- instr_address  output  32  byte address to ROM; always equals the PC register.
- instr_readdata  input  32  ROM word at instr_address, valid in the same cycle (combinational ROM).
- stall  input  1  hold PC and all decode-stage outputs.
- branch_valid  input  1  taken branch/jump being decoded from instr_out this cycle.
- branch_target  input  32  redirect address, sampled when branch_valid=1.
- instr_out  output  32  registered instruction for decode.
- pc_out  output  32  address of instr_out.
- pc_plus8  output  32  pc_out+8 (link address for JAL/JALR/BGEZAL/BLTZAL).
- instr_valid  output  1  instr_out holds a real instruction.
- active  output  1  core is running (not halted or in error).
- fetch_error  output  1  misaligned redirect detected; sticky until reset.

## Operation
- States: RUN, HALTED, ERROR. Reset enters RUN.
- Reset values: PC=RESET_VECTOR, instr_out=0, pc_out=0, pc_plus8=8, instr_valid=0, active=1, fetch_error=0, pending_valid=0, pending_target=0.
- RUN, stall=0, PC≠HALT_ADDR:
  - instr_out←instr_readdata, pc_out←PC, pc_plus8←PC+8, instr_valid←1.
  - PC←next_pc.
- next_pc selection, in priority order:
  - branch_valid ? branch_target
  - pending_valid ? pending_target (then pending_valid←0)
  - PC+4
- Delay slot: branch_valid refers to the instruction in instr_out. The word fetched in that same cycle (at PC) is the delay slot and is always issued; the target is fetched next.
- RUN, stall=1:
  - PC, instr_out, pc_out, pc_plus8 and instr_valid hold.
  - If branch_valid=1: pending_target←branch_target, pending_valid←1, so the redirect survives the stall.
- Halt: in RUN with PC==HALT_ADDR and stall=0, go to HALTED.
  - instr_valid←0, active←0. PC holds at HALT_ADDR.
  - ROM data at address 0 is never captured.
- Misalignment: if the value about to load into PC has bits[1:0]≠0, go to ERROR.
  - fetch_error←1, active←0, instr_valid←0. PC is not updated.
  - The delay slot captured in that cycle is still written to instr_out but with instr_valid=0.
- HALTED and ERROR are terminal. All inputs are ignored and outputs hold until reset.
- Arithmetic is 32-bit unsigned and wraps modulo 2^32; 0xFFFFFFFC+4=0x00000000, which triggers halt.
- Asserting reset mid-operation (including during stall or with pending_valid=1) immediately restores all reset values; any pending redirect is discarded.

## Timing
- Fetch-to-decode latency: 1 cycle. The word at PC in cycle n appears on instr_out in cycle n+1.
- Redirect: branch_valid in cycle n → delay slot on instr_out in n+1 → target on instr_address in n+1 and on instr_out in n+2.
- Stalled redirect: the target is applied on the first unstalled edge. Sequence is identical to the unstalled case, shifted by the stall length.
- branch_valid and pending_valid together: the live branch_target wins and the pending entry is cleared. This case is legal only if decode re-presents the same branch.
- Halt is visible (active=0) one cycle after PC becomes HALT_ADDR.
- fetch_error rises on the edge that would have loaded the bad PC.
- Outputs are registered except instr_address, which is driven directly from the PC flop.

## Test plan
- Reset/sequential: release reset with ROM words 0x24020005, 0x24030007 at 0xBFC00000/04 → cycle 1: instr_address=0xBFC00000, instr_valid=0. Cycle 2: instr_out=0x24020005, pc_out=0xBFC00000, pc_plus8=0xBFC00008. Cycle 3: instr_out=0x24030007.
- Delay slot: branch_valid=1, target 0xBFC00100 while instr_out is from 0xBFC00008 → next instr_out from 0xBFC0000C (delay slot), then from 0xBFC00100.
- Stalled branch: stall=1 for 3 cycles with branch_valid pulsed in the first stall cycle, target 0xBFC00040 → outputs frozen for 3 cycles. After release, the delay slot issues, then pc_out=0xBFC00040.
- Halt: JR to 0x00000000 → delay slot issues with instr_valid=1. One cycle later active=0 and instr_valid=0, and both stay low for 10+ cycles.
- Misaligned: branch_target=0xBFC00102 → fetch_error=1, active=0 on the next edge. instr_address stays unchanged.
- Reset mid-run: assert reset asynchronously between edges while pending_valid=1 → outputs go to reset values immediately, without waiting for a clock edge. After release, fetch restarts at 0xBFC00000 with no redirect.
